// File: rtl/rle_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rle_cfg_sequencer
// Purpose  : AXI4-Lite master that programs four consecutive config registers
//            and reads each one back to verify it before moving on.
// Revision : 1.0  initial release
// ============================================================================
module rle_cfg_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter int                            C_TIMEOUT          = 256
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              start,
    input  logic [127:0]                      cfg_data,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [1:0]                        err_code,
    output logic [1:0]                        err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int c_CNT_W = $clog2(C_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD      = 3'd3,
        S_RD_DATA = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [1:0]                      r_idx;
    logic [127:0]                    r_cfg;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            r_error;
    logic [1:0]                      r_err_code;
    logic [1:0]                      r_err_index;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;

    logic [31:0]                     w_word;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_word_ext;
    logic [1:0]                      w_idx_inc;
    logic                            w_tmo;
    logic                            w_timed;
    logic                            w_advance;
    logic [1:0]                      w_fail_code;
    logic                            w_awvalid;
    logic                            w_wvalid;
    logic                            w_bready;
    logic                            w_arvalid;
    logic                            w_rready;

    assign w_word     = r_cfg[{r_idx, 5'b00000} +: 32];
    assign w_word_ext = C_M_AXI_DATA_WIDTH'(w_word);
    assign w_idx_inc  = r_idx + 2'd1;
    assign w_tmo      = (r_cnt == c_CNT_W'(C_TIMEOUT - 1));
    assign w_timed    = (r_state == S_WR) || (r_state == S_WR_RESP) ||
                        (r_state == S_RD) || (r_state == S_RD_DATA);

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_fail_code = 2'b00;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_WR;
            end
            S_WR: begin
                // AW and W retire independently; leave only once both have landed
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) begin
                    w_state_nxt = S_WR_RESP;
                end else if (w_tmo) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = 2'b11;
                end
            end
            S_WR_RESP: begin
                w_bready = 1'b1;
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP == 2'b00) begin
                        w_state_nxt = S_RD;
                    end else begin
                        w_state_nxt = S_FAIL;
                        w_fail_code = 2'b01;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = 2'b11;
                end
            end
            S_RD: begin
                w_arvalid = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_state_nxt = S_RD_DATA;
                end else if (w_tmo) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = 2'b11;
                end
            end
            S_RD_DATA: begin
                w_rready = 1'b1;
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP == 2'b00) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_FAIL;
                        w_fail_code = 2'b01;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = 2'b11;
                end
            end
            S_CHECK: begin
                if (r_rdata == w_word_ext) begin
                    w_advance   = 1'b1;
                    w_state_nxt = (r_idx == 2'd3) ? S_DONE : S_WR;
                end else begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = 2'b10;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cfg       <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_index <= 2'b00;
            r_addr      <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Per-state cycle budget restarts on every state change
            if ((w_state_nxt != r_state) || !w_timed) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((w_state_nxt == S_WR) && (r_state != S_WR)) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state == S_WR) begin
                if (M_AXI_AWREADY) r_aw_done <= 1'b1;
                if (M_AXI_WREADY)  r_w_done  <= 1'b1;
            end

            if ((r_state == S_IDLE) && start) begin
                r_cfg       <= cfg_data;
                r_idx       <= 2'd0;
                r_addr      <= C_BASE_ADDR;
                r_error     <= 1'b0;
                r_err_code  <= 2'b00;
                r_err_index <= 2'b00;
            end

            if (w_advance && (r_idx != 2'd3)) begin
                r_idx  <= w_idx_inc;
                r_addr <= C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({w_idx_inc, 2'b00});
            end

            if ((r_state == S_RD_DATA) && M_AXI_RVALID) begin
                r_rdata <= M_AXI_RDATA;
            end

            if ((w_state_nxt == S_FAIL) && (r_state != S_FAIL)) begin
                r_error     <= 1'b1;
                r_err_code  <= w_fail_code;
                r_err_index <= r_idx;
            end
        end
    end

    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done          = (r_state == S_DONE);
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign err_index     = r_err_index;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = w_word_ext;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = w_awvalid;
    assign M_AXI_WVALID  = w_wvalid;
    assign M_AXI_BREADY  = w_bready;
    assign M_AXI_ARVALID = w_arvalid;
    assign M_AXI_RREADY  = w_rready;

endmodule
`default_nettype wire

// File: tb/tb_rle_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_cfg_sequencer
// Purpose  : Self-checking bench: AXI4-Lite slave with fault injection, a
//            vector table, reset sequences and randomized runs vs a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rle_cfg_sequencer;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TMO  = 256;

    typedef struct {
        logic [127:0] cfg;
        int           aw_dly, w_dly, ar_dly, rsp_dly;
        int           bad_bresp, bad_rresp, bad_rdata;
        logic [31:0]  bad_word;
        bit           stuck_ar;
        bit           exp_done;
        logic [1:0]   exp_code, exp_idx;
        int           exp_nwr, exp_nrd;
    } vec_t;

    logic            tb_ACLK = 1'b0;
    logic            tb_ARESETN;
    logic            start;
    logic [127:0]    cfg_data;
    logic            busy, done, error;
    logic [1:0]      err_code, err_index;
    logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic            M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY;
    logic            M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    always #5 tb_ACLK = ~tb_ACLK;

    rle_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_BASE_ADDR(BASE), .C_TIMEOUT(TMO)
    ) dut (
        .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- slave model ----------------
    int          aw_dly, w_dly, ar_dly, rsp_dly;
    int          bad_bresp, bad_rresp, bad_rdata;
    logic [31:0] bad_word;
    bit          stuck_ar;
    logic [31:0] mem [4];
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    logic [31:0] pend_aw[$], pend_w[$], r_data_q[$];
    logic [1:0]  b_q[$], r_resp_q[$];
    int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait, arv_cycles;
    bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [31:0] hs_aw_addr, hs_w_data, hs_ar_addr;

    // Slave drives at falling edges; hs_* predicts the handshake at the next rising edge
    always @(negedge tb_ACLK) begin
        logic [31:0] a, d, off;
        int          k;
        if (!tb_ARESETN) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0;
            M_AXI_RDATA = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            pend_aw.delete(); pend_w.delete(); b_q.delete(); r_data_q.delete(); r_resp_q.delete();
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (hs_aw) pend_aw.push_back(hs_aw_addr);
            if (hs_w)  pend_w.push_back(hs_w_data);
            while (pend_aw.size() > 0 && pend_w.size() > 0) begin
                a = pend_aw.pop_front();
                d = pend_w.pop_front();
                off = a - BASE;
                k = int'(off[3:2]);
                wr_addr_q.push_back(a);
                wr_data_q.push_back(d);
                mem[k] = d;
                b_q.push_back((k == bad_bresp) ? 2'b10 : 2'b00);
            end
            if (hs_b) M_AXI_BVALID = 0;
            if (hs_ar) begin
                off = hs_ar_addr - BASE;
                k = int'(off[3:2]);
                rd_addr_q.push_back(hs_ar_addr);
                r_data_q.push_back((k == bad_rdata) ? bad_word : mem[k]);
                r_resp_q.push_back((k == bad_rresp) ? 2'b10 : 2'b00);
            end
            if (hs_r) M_AXI_RVALID = 0;

            M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
            if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
            M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_dly);
            if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt++;
            M_AXI_ARREADY = M_AXI_ARVALID && !stuck_ar && (ar_cnt >= ar_dly);
            if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_cnt++;
            if (M_AXI_ARVALID) arv_cycles++;

            if (!M_AXI_BVALID && b_q.size() > 0) begin
                if (b_wait >= rsp_dly) begin
                    M_AXI_BVALID = 1; M_AXI_BRESP = b_q.pop_front(); b_wait = 0;
                end else b_wait++;
            end
            if (!M_AXI_RVALID && r_data_q.size() > 0) begin
                if (r_wait >= rsp_dly) begin
                    M_AXI_RVALID = 1; M_AXI_RDATA = r_data_q.pop_front();
                    M_AXI_RRESP = r_resp_q.pop_front(); r_wait = 0;
                end else r_wait++;
            end

            hs_aw = M_AXI_AWVALID && M_AXI_AWREADY; hs_aw_addr = M_AXI_AWADDR;
            hs_w  = M_AXI_WVALID && M_AXI_WREADY;   hs_w_data  = M_AXI_WDATA;
            hs_ar = M_AXI_ARVALID && M_AXI_ARREADY; hs_ar_addr = M_AXI_ARADDR;
            hs_b  = M_AXI_BVALID && M_AXI_BREADY;
            hs_r  = M_AXI_RVALID && M_AXI_RREADY;
            if (hs_aw) aw_cnt = 0;
            if (hs_w)  w_cnt = 0;
            if (hs_ar) ar_cnt = 0;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outcome of a pass derived register by register from the fault configuration
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_done = 0; r.exp_code = 2'b00; r.exp_idx = 2'b00; r.exp_nwr = 0; r.exp_nrd = 0;
        for (int k = 0; k < 4; k++) begin
            r.exp_nwr++;
            r.exp_idx = 2'(k);
            if (k == v.bad_bresp) begin r.exp_code = 2'b01; return r; end
            if (v.stuck_ar)       begin r.exp_code = 2'b11; return r; end
            r.exp_nrd++;
            if (k == v.bad_rresp) begin r.exp_code = 2'b01; return r; end
            if (k == v.bad_rdata && v.bad_word != v.cfg[32*k +: 32]) begin
                r.exp_code = 2'b10; return r;
            end
        end
        r.exp_done = 1; r.exp_idx = 2'b00;
        return r;
    endfunction

    task automatic cfg_slave(input vec_t v);
        @(posedge tb_ACLK); #1;
        aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly; rsp_dly = v.rsp_dly;
        bad_bresp = v.bad_bresp; bad_rresp = v.bad_rresp; bad_rdata = v.bad_rdata;
        bad_word = v.bad_word; stuck_ar = v.stuck_ar;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        arv_cycles = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int extra_at);
        int cyc, done_cnt, errs;
        cfg_slave(v);
        @(negedge tb_ACLK); start = 1; cfg_data = v.cfg;
        @(negedge tb_ACLK); start = 0;
        cfg_data = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " error_cleared"}, error, 0);
        cyc = 0; done_cnt = 0;
        while (!(error || done_cnt > 0) && cyc < 3000) begin
            start = (cyc == extra_at);
            @(negedge tb_ACLK);
            cyc++;
            if (done) done_cnt++;
        end
        start = 0;
        chk({tag, " finished_in_bound"}, cyc < 3000, 1);
        repeat (3) begin
            @(negedge tb_ACLK);
            if (done) done_cnt++;
        end
        chk({tag, " done_pulses"}, done_cnt, v.exp_done ? 1 : 0);
        chk({tag, " error"}, error, !v.exp_done);
        chk({tag, " err_code"}, err_code, v.exp_code);
        chk({tag, " err_index"}, err_index, v.exp_idx);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " valids_idle"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                                    M_AXI_BREADY, M_AXI_RREADY}, 0);
        chk({tag, " n_writes"}, wr_addr_q.size(), v.exp_nwr);
        chk({tag, " n_reads"}, rd_addr_q.size(), v.exp_nrd);
        errs = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            if (wr_addr_q[i] != BASE + 32'(4 * i)) errs++;
            if (wr_data_q[i] != v.cfg[32*i +: 32]) errs++;
        end
        for (int i = 0; i < rd_addr_q.size() && i < 4; i++)
            if (rd_addr_q[i] != BASE + 32'(4 * i)) errs++;
        chk({tag, " addr_data_log"}, errs, 0);
        if (v.exp_code == 2'b11)
            chk({tag, " arvalid_cycles"}, arv_cycles, TMO);
    endtask

    localparam logic [127:0] C0 = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
    localparam logic [127:0] C1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    vec_t tbl [9];
    vec_t rv;
    int   wcyc;

    initial begin
        //          cfg aw w ar rsp  bb  br  bd  bad_word    stk  done code   idx  nwr nrd
        tbl[0] = '{C0, 0, 0, 0, 0,  -1, -1, -1, 32'h0,        0,  1, 2'b00, 2'd0, 4, 4};
        tbl[1] = '{C0, 3, 0, 0, 0,  -1, -1, -1, 32'h0,        0,  1, 2'b00, 2'd0, 4, 4};
        tbl[2] = '{C0, 0, 3, 0, 0,  -1, -1, -1, 32'h0,        0,  1, 2'b00, 2'd0, 4, 4};
        tbl[3] = '{C0, 0, 0, 0, 0,  -1, -1,  2, 32'hdead0010, 0,  0, 2'b10, 2'd2, 3, 3};
        tbl[4] = '{C0, 0, 0, 0, 0,   1, -1, -1, 32'h0,        0,  0, 2'b01, 2'd1, 2, 1};
        tbl[5] = '{C0, 1, 2, 1, 1,  -1, -1, -1, 32'h0,        0,  1, 2'b00, 2'd0, 4, 4};
        tbl[6] = '{C0, 0, 0, 0, 0,  -1, -1, -1, 32'h0,        1,  0, 2'b11, 2'd0, 1, 0};
        tbl[7] = '{C1, 2, 2, 0, 3,  -1,  3, -1, 32'h0,        0,  0, 2'b01, 2'd3, 4, 4};
        tbl[8] = '{C1, 0, 0, 4, 2,  -1, -1, -1, 32'h0,        0,  1, 2'b00, 2'd0, 4, 4};

        tb_ARESETN = 0; start = 0; cfg_data = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; rsp_dly = 0;
        bad_bresp = -1; bad_rresp = -1; bad_rdata = -1; bad_word = 0; stuck_ar = 0;
        repeat (3) @(negedge tb_ACLK);
        chk("rst status", {busy, done, error, err_code, err_index}, 0);
        chk("rst handshakes", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                               M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("rst addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
        @(negedge tb_ACLK); tb_ARESETN = 1;
        repeat (2) @(negedge tb_ACLK);
        chk("idle without start", busy, 0);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i), -1);

        // Asynchronous reset while waiting on read data for register 1
        rv = tbl[0]; rv.rsp_dly = 6;
        cfg_slave(rv);
        @(negedge tb_ACLK); start = 1; cfg_data = C0;
        @(negedge tb_ACLK); start = 0;
        wcyc = 0;
        while (!(M_AXI_RREADY && M_AXI_ARADDR == 32'h4) && wcyc < 500) begin
            @(negedge tb_ACLK); wcyc++;
        end
        chk("reach rd_data idx1", wcyc < 500, 1);
        #2 tb_ARESETN = 0;
        #1;
        chk("async rst status", {busy, done, error, err_code, err_index}, 0);
        chk("async rst handshakes", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                     M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("async rst addr", M_AXI_ARADDR, 0);
        @(negedge tb_ACLK);
        @(negedge tb_ACLK); tb_ARESETN = 1;
        repeat (5) @(negedge tb_ACLK);
        chk("no restart after rst", {busy, M_AXI_AWVALID, M_AXI_ARVALID}, 0);
        run_vec(tbl[0], "post_rst extra_start", 5);

        for (int n = 0; n < 24; n++) begin
            rv.cfg       = {$urandom, $urandom, $urandom, $urandom};
            rv.aw_dly    = $urandom_range(0, 4);
            rv.w_dly     = $urandom_range(0, 4);
            rv.ar_dly    = $urandom_range(0, 4);
            rv.rsp_dly   = $urandom_range(0, 4);
            rv.bad_bresp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            rv.bad_rresp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            rv.bad_rdata = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            rv.bad_word  = $urandom;
            rv.stuck_ar  = ($urandom_range(0, 9) == 0);
            rv = model(rv);
            run_vec(rv, $sformatf("rand%0d", n), ($urandom_range(0, 1) == 0) ? 3 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
